// File: rtl/axis_mux_pkg.sv
// Shared types, defaults and helpers for the round-robin AXI-Stream multiplexer.
package axis_mux_pkg;

  typedef enum logic {
    ARB = 1'b0,
    GAP = 1'b1
  } mux_state_e;

  localparam int unsigned DEF_N_CH       = 15;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_GAP_CYCLES = 3;
  localparam int unsigned DEF_SKIP_IDLE  = 1;
  localparam int unsigned GAP_W          = 4;

  // Pointer advance with wrap from the last channel back to channel 0.
  function automatic int unsigned ptr_wrap_inc(int unsigned idx, int unsigned n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Rotating-priority encoder: first asserted request at or after base, wrapping modulo N_CH.
module axis_rr_pick
  import axis_mux_pkg::*;
#(
  parameter  int unsigned N_CH = DEF_N_CH,
  localparam int unsigned CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [CH_W-1:0] base_i,
  output logic [CH_W-1:0] grant_o,
  output logic            any_o
);

  int unsigned idx;

  // Scan from the farthest offset down so the nearest request to base wins.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    idx     = 0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      idx = 32'(base_i) + 32'(i);
      if (idx >= N_CH) idx = idx - N_CH;
      if (req_i[CH_W'(idx)]) begin
        grant_o = CH_W'(idx);
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_rr_mux.sv
// N-to-1 round-robin stream multiplexer with forced inter-beat gap and registered output.
module axis_rr_mux
  import axis_mux_pkg::*;
#(
  parameter  int unsigned N_CH       = DEF_N_CH,
  parameter  int unsigned DATA_W     = DEF_DATA_W,
  parameter  int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
  parameter  int unsigned SKIP_IDLE  = DEF_SKIP_IDLE,
  localparam int unsigned CH_W       = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*DATA_W-1:0]   s_data,
  input  logic [N_CH-1:0]          s_valid,
  output logic [N_CH-1:0]          s_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [CH_W-1:0]          m_chan
);

  mux_state_e        state_q;
  logic [CH_W-1:0]   ptr_q;
  logic [CH_W-1:0]   ptr_d;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic [DATA_W-1:0] m_data_q;
  logic              m_valid_q;
  logic [CH_W-1:0]   m_chan_q;

  logic [CH_W-1:0]   grant;
  logic              grant_any;
  logic              accept_ok;
  logic              xfer;
  logic [DATA_W-1:0] sel_data;

  // Grant source: rotating search in skip-idle mode, fixed pointer in legacy mode.
  if (SKIP_IDLE != 0) begin : g_skip
    axis_rr_pick #(.N_CH(N_CH)) u_pick (
      .req_i   (s_valid),
      .base_i  (ptr_q),
      .grant_o (grant),
      .any_o   (grant_any)
    );
  end else begin : g_legacy
    assign grant     = ptr_q;
    assign grant_any = 1'b1;
  end

  assign sel_data = s_data[grant*DATA_W +: DATA_W];
  assign ptr_d    = CH_W'(ptr_wrap_inc(32'(grant), N_CH));
  assign xfer     = |(s_ready & s_valid);

  // Ready is offered only in ARB with room in the output register.
  always_comb begin
    accept_ok = (state_q == ARB) && (!m_valid_q || m_ready) && !rst;
    s_ready   = '0;
    if (accept_ok && grant_any) s_ready[grant] = 1'b1;
  end

  // Arbitration/gap FSM with output beat register; drain and load may share an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB;
      ptr_q     <= '0;
      gap_cnt_q <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_chan_q  <= '0;
    end else begin
      if (m_valid_q && m_ready) m_valid_q <= 1'b0;
      case (state_q)
        ARB: begin
          if (xfer) begin
            m_data_q  <= sel_data;
            m_chan_q  <= grant;
            m_valid_q <= 1'b1;
            ptr_q     <= ptr_d;
            if (GAP_CYCLES > 0) begin
              state_q   <= GAP;
              gap_cnt_q <= GAP_W'(GAP_CYCLES - 1);
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == '0) state_q <= ARB;
          else gap_cnt_q <= gap_cnt_q - 1'b1;
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_chan  = m_chan_q;

endmodule

// File: doc/axis_rr_mux.md
# axis_rr_mux

Parametrised N-to-1 AXI-Stream-style multiplexer that merges several producer channels into a single consumer stream with round-robin fairness. It generalises the fixed 15-channel, 32-bit interconnect: configurable channel count, data width and inter-beat gap, an optional skip-idle arbitration mode, a true valid/ready handshake on the output, and a reported channel index. It sits between the per-channel pixel/data producers and the single processing core input.

## Interface
- N_CH, 15, number of input channels (2..32)
- DATA_W, 32, data width in bits
- GAP_CYCLES, 3, idle cycles forced after every accepted beat (0..15)
- SKIP_IDLE, 1, 1: grant the next valid channel from the pointer; 0: wait on the pointer channel until it is valid (legacy mode)
- CH_W, derived, $clog2(N_CH)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_data  in  N_CH*DATA_W  flattened channel data, channel k at bits [k*DATA_W +: DATA_W]
- s_valid  in  N_CH  per-channel valid
- s_ready  out  N_CH  per-channel ready, one-hot or zero
- m_data  out  DATA_W  registered output data
- m_valid  out  1  output beat valid
- m_ready  in  1  consumer ready
- m_chan  out  CH_W  index of the channel that produced m_data

## Operation
- Transfer on any port occurs when valid & ready are both high on a rising edge.
- States: ARB, GAP.
- accept_ok = (state == ARB) && (!m_valid || m_ready) && !rst.
- ARB, SKIP_IDLE=1: grant = first k with s_valid[k], searching ptr, ptr+1, ... N_CH-1, 0, ... ptr-1. s_ready = onehot(grant) when accept_ok and any s_valid, else 0.
- ARB, SKIP_IDLE=0: grant = ptr; s_ready[ptr] = accept_ok regardless of s_valid[ptr].
- On transfer from channel g: m_data <= s_data[g], m_chan <= g, m_valid <= 1, ptr <= (g == N_CH-1) ? 0 : g+1; if GAP_CYCLES > 0 go to GAP with gap_cnt <= GAP_CYCLES-1, else stay in ARB.
- No transfer in ARB: ptr and state unchanged.
- GAP: s_ready all 0; gap_cnt decrements; at gap_cnt == 0 return to ARB. Gap count runs independently of m_ready.
- Output: m_valid holds with stable m_data/m_chan until m_valid & m_ready; clears on that edge unless a new beat is loaded the same edge.

## Timing
- Reset values: m_valid 0, m_data 0, m_chan 0, s_ready 0, ptr 0, state ARB, gap_cnt 0.
- Latency: input transfer at edge t -> m_valid high after edge t.
- Max throughput: one beat per GAP_CYCLES+1 cycles; with GAP_CYCLES=0 one beat per cycle under continuous m_ready.
- s_ready depends combinationally on m_ready, s_valid, state; no path from s_valid to m_valid without a register.
- Back-pressure: m_valid=1, m_ready=0 -> s_ready all 0, ptr frozen, GAP still counts down.
- Simultaneous output drain and input accept in one edge: both happen, m_valid stays 1 with the new beat.
- Wrap: grant of N_CH-1 -> ptr 0; search wraps modulo N_CH.
- Reset mid-operation: held output beat is discarded (m_valid 0 next cycle), GAP aborted.

## Structure
- Package axis_mux_pkg: state enum (ARB, GAP), ptr wrap helper function, default parameter constants.
- Sub-module axis_rr_pick: combinational rotating-priority encoder (inputs req[N_CH], base ptr; outputs grant index, any); instantiated only when SKIP_IDLE=1.

## Test plan
- Reset, then s_valid=15'h7FFF, m_ready=1, GAP=3: beats from channels 0,1,...,14,0 in order, one every 4 cycles, m_chan matches, data = s_data of that channel.
- SKIP_IDLE=1, only channels 3 and 9 valid, ptr 0: grants 3, 9, 3, 9; ptr after 9 = 10, after 3 = 4.
- SKIP_IDLE=0, only channel 5 valid, ptr 0: no transfer for channels 0..4; s_ready[0] high and waits; m_valid stays 0.
- GAP=0, all valid, m_ready toggling 1010: no beat lost or duplicated, m_data stable while m_ready=0, one beat per m_ready=1 cycle.
- Channel 14 granted -> next grant channel 0 (wrap); rst pulsed while m_valid=1, m_ready=0 -> m_valid 0 next cycle, next grant from channel 0.
